// File: rtl/wb_regfile_scoreboard.sv
// 32x32 register file with a per-register pending-write scoreboard and hazard stall.
// Optional macro WB_BYPASS_EN forwards the retiring write-back value to the read ports.
module wb_regfile_scoreboard #(
   parameter int MAX_INFLIGHT = 3
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        RegWrite_WB,
   input  logic        MemtoReg_WB,
   input  logic [31:0] Read_Data_WB,
   input  logic [31:0] ALU_Result_WB,
   input  logic [4:0]  Write_Register_WB,
   input  logic [4:0]  Read_Register_1_ID,
   input  logic [4:0]  Read_Register_2_ID,
   input  logic        Uses_Rs_ID,
   input  logic        Uses_Rt_ID,
   input  logic        Issue_ID,
   input  logic        Issue_RegWrite_ID,
   input  logic [4:0]  Issue_Write_Register_ID,
   output logic [31:0] Read_Data_1_ID,
   output logic [31:0] Read_Data_2_ID,
   output logic        Stall_ID,
   output logic        Sb_Error
);

   localparam logic [1:0] MaxCount = 2'(MAX_INFLIGHT);

   logic [31:0] regFile_q   [32];
   logic [1:0]  pendCount_q [32];
   logic [1:0]  pendCount_d [32];
   logic        sbError_q;
   logic        sbError_d;
   logic [31:0] wbData;
   logic [31:0] retireVec;
   logic [31:0] issueVec;
   logic [31:0] busyVec;
   logic        accept;

   assign wbData = MemtoReg_WB ? Read_Data_WB : ALU_Result_WB;

   // Entry 0 of every vector stays clear so $0 is never tracked and never stalls.
   always_comb begin
      retireVec = '0;
      issueVec  = '0;
      busyVec   = '0;
      for (int r = 1; r < 32; r++) begin
         retireVec[r] = RegWrite_WB && (Write_Register_WB == 5'(r));
         issueVec[r]  = Issue_RegWrite_ID && (Issue_Write_Register_ID == 5'(r));
`ifdef WB_BYPASS_EN
         busyVec[r]   = (pendCount_q[r] - {1'b0, retireVec[r]}) != 2'd0;
`else
         busyVec[r]   = pendCount_q[r] != 2'd0;
`endif
      end
   end

   assign Stall_ID = (Uses_Rs_ID && busyVec[Read_Register_1_ID]) ||
                     (Uses_Rt_ID && busyVec[Read_Register_2_ID]);
   assign accept   = Issue_ID && !Stall_ID;

   // Simultaneous issue and retire of the same register cancel out.
   always_comb begin
      sbError_d = sbError_q;
      for (int r = 0; r < 32; r++) begin
         pendCount_d[r] = pendCount_q[r];
      end
      pendCount_d[0] = 2'd0;
      for (int r = 1; r < 32; r++) begin
         if (accept && issueVec[r] && !retireVec[r]) begin
            if (pendCount_q[r] >= MaxCount) begin
               sbError_d = 1'b1;
            end else begin
               pendCount_d[r] = pendCount_q[r] + 2'd1;
            end
         end else if (retireVec[r] && !(accept && issueVec[r])) begin
            if (pendCount_q[r] == 2'd0) begin
               sbError_d = 1'b1;
            end else begin
               pendCount_d[r] = pendCount_q[r] - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int r = 0; r < 32; r++) begin
            pendCount_q[r] <= 2'd0;
            regFile_q[r]   <= 32'd0;
         end
         sbError_q <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) begin
            pendCount_q[r] <= pendCount_d[r];
         end
         sbError_q <= sbError_d;
         if (RegWrite_WB && (Write_Register_WB != 5'd0)) begin
            regFile_q[Write_Register_WB] <= wbData;
         end
      end
   end

   assign Sb_Error = sbError_q;

   always_comb begin
      Read_Data_1_ID = regFile_q[Read_Register_1_ID];
      Read_Data_2_ID = regFile_q[Read_Register_2_ID];
`ifdef WB_BYPASS_EN
      if (retireVec[Read_Register_1_ID]) begin
         Read_Data_1_ID = wbData;
      end
      if (retireVec[Read_Register_2_ID]) begin
         Read_Data_2_ID = wbData;
      end
`endif
      if (Read_Register_1_ID == 5'd0) begin
         Read_Data_1_ID = 32'd0;
      end
      if (Read_Register_2_ID == 5'd0) begin
         Read_Data_2_ID = 32'd0;
      end
   end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed self-checking bench for wb_regfile_scoreboard (default MAX_INFLIGHT=3).
// Expectations for the retire cycle follow WB_BYPASS_EN when the bench is built with it.
module tb_wb_regfile_scoreboard;

`ifdef WB_BYPASS_EN
   localparam bit BypassEn = 1'b1;
`else
   localparam bit BypassEn = 1'b0;
`endif

   logic        Clk;
   logic        Reset_n;
   logic        RegWrite_WB;
   logic        MemtoReg_WB;
   logic [31:0] Read_Data_WB;
   logic [31:0] ALU_Result_WB;
   logic [4:0]  Write_Register_WB;
   logic [4:0]  Read_Register_1_ID;
   logic [4:0]  Read_Register_2_ID;
   logic        Uses_Rs_ID;
   logic        Uses_Rt_ID;
   logic        Issue_ID;
   logic        Issue_RegWrite_ID;
   logic [4:0]  Issue_Write_Register_ID;
   logic [31:0] Read_Data_1_ID;
   logic [31:0] Read_Data_2_ID;
   logic        Stall_ID;
   logic        Sb_Error;

   int vectors     = 0;
   int miscompares = 0;

   wb_regfile_scoreboard #(.MAX_INFLIGHT(3)) dut (
      .Clk                     (Clk),
      .Reset_n                 (Reset_n),
      .RegWrite_WB             (RegWrite_WB),
      .MemtoReg_WB             (MemtoReg_WB),
      .Read_Data_WB            (Read_Data_WB),
      .ALU_Result_WB           (ALU_Result_WB),
      .Write_Register_WB       (Write_Register_WB),
      .Read_Register_1_ID      (Read_Register_1_ID),
      .Read_Register_2_ID      (Read_Register_2_ID),
      .Uses_Rs_ID              (Uses_Rs_ID),
      .Uses_Rt_ID              (Uses_Rt_ID),
      .Issue_ID                (Issue_ID),
      .Issue_RegWrite_ID       (Issue_RegWrite_ID),
      .Issue_Write_Register_ID (Issue_Write_Register_ID),
      .Read_Data_1_ID          (Read_Data_1_ID),
      .Read_Data_2_ID          (Read_Data_2_ID),
      .Stall_ID                (Stall_ID),
      .Sb_Error                (Sb_Error)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Inputs change 1 time unit after the rising edge and are checked 1 unit later.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idleInputs();
      RegWrite_WB             = 1'b0;
      MemtoReg_WB             = 1'b0;
      Read_Data_WB            = 32'd0;
      ALU_Result_WB           = 32'd0;
      Write_Register_WB       = 5'd0;
      Read_Register_1_ID      = 5'd0;
      Read_Register_2_ID      = 5'd0;
      Uses_Rs_ID              = 1'b0;
      Uses_Rt_ID              = 1'b0;
      Issue_ID                = 1'b0;
      Issue_RegWrite_ID       = 1'b0;
      Issue_Write_Register_ID = 5'd0;
   endtask

   task automatic issueWrite(input logic [4:0] dest);
      idleInputs();
      Issue_ID                = 1'b1;
      Issue_RegWrite_ID       = 1'b1;
      Issue_Write_Register_ID = dest;
   endtask

   task automatic retireAlu(input logic [4:0] dest, input logic [31:0] value);
      idleInputs();
      RegWrite_WB       = 1'b1;
      Write_Register_WB = dest;
      ALU_Result_WB     = value;
      Read_Data_WB      = 32'hDEADBEEF;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      idleInputs();
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd5;
      Uses_Rt_ID = 1'b1; Read_Register_2_ID = 5'd31;
      tick(); tick();
      vectors++; if (Read_Data_1_ID !== 32'd0) begin miscompares++;
         $display("[TB] FAIL rst_read1: got %h expected %h", Read_Data_1_ID, 32'd0); end
      vectors++; if (Read_Data_2_ID !== 32'd0) begin miscompares++;
         $display("[TB] FAIL rst_read2: got %h expected %h", Read_Data_2_ID, 32'd0); end
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL rst_stall: got %b expected 0", Stall_ID); end
      vectors++; if (Sb_Error !== 1'b0) begin miscompares++;
         $display("[TB] FAIL rst_sberr: got %b expected 0", Sb_Error); end
      Reset_n = 1'b1;
      tick();
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL rst_first_cycle_stall: got %b expected 0", Stall_ID); end
   endtask

   task automatic test_issue_retire();
      issueWrite(5'd5);
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL ir_issue_accept: got %b expected 0", Stall_ID); end
      tick();
      idleInputs();
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd5;
      #1;
      vectors++; if (Stall_ID !== 1'b1) begin miscompares++;
         $display("[TB] FAIL ir_pending_c1: got %b expected 1", Stall_ID); end
      tick();
      vectors++; if (Stall_ID !== 1'b1) begin miscompares++;
         $display("[TB] FAIL ir_pending_c2: got %b expected 1", Stall_ID); end
      tick();
      retireAlu(5'd5, 32'h0000_1234);
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd5;
      Uses_Rt_ID = 1'b1; Read_Register_2_ID = 5'd5;
      #1;
      vectors++; if (Stall_ID !== !BypassEn) begin miscompares++;
         $display("[TB] FAIL ir_retire_stall: got %b expected %b", Stall_ID, !BypassEn); end
      vectors++; if (Read_Data_1_ID !== (BypassEn ? 32'h1234 : 32'h0)) begin miscompares++;
         $display("[TB] FAIL ir_retire_read1: got %h expected %h", Read_Data_1_ID,
                  (BypassEn ? 32'h1234 : 32'h0)); end
      vectors++; if (Read_Data_2_ID !== (BypassEn ? 32'h1234 : 32'h0)) begin miscompares++;
         $display("[TB] FAIL ir_retire_read2: got %h expected %h", Read_Data_2_ID,
                  (BypassEn ? 32'h1234 : 32'h0)); end
      tick();
      RegWrite_WB = 1'b0;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL ir_after_stall: got %b expected 0", Stall_ID); end
      vectors++; if (Read_Data_1_ID !== 32'h1234) begin miscompares++;
         $display("[TB] FAIL ir_after_read: got %h expected %h", Read_Data_1_ID, 32'h1234); end
   endtask

   task automatic test_load_writeback();
      issueWrite(5'd12);
      tick();
      idleInputs();
      RegWrite_WB = 1'b1; Write_Register_WB = 5'd12; MemtoReg_WB = 1'b1;
      Read_Data_WB = 32'hCAFEF00D; ALU_Result_WB = 32'h1111_1111;
      tick();
      idleInputs();
      Read_Register_1_ID = 5'd12; Read_Register_2_ID = 5'd5;
      #1;
      vectors++; if (Read_Data_1_ID !== 32'hCAFEF00D) begin miscompares++;
         $display("[TB] FAIL ld_read12: got %h expected %h", Read_Data_1_ID, 32'hCAFEF00D); end
      vectors++; if (Read_Data_2_ID !== 32'h1234) begin miscompares++;
         $display("[TB] FAIL ld_read5_kept: got %h expected %h", Read_Data_2_ID, 32'h1234); end
      vectors++; if (Sb_Error !== 1'b0) begin miscompares++;
         $display("[TB] FAIL ld_sberr: got %b expected 0", Sb_Error); end
   endtask

   task automatic test_hazard();
      issueWrite(5'd7);
      tick();
      // A second issue while stalled must not be counted for $20.
      issueWrite(5'd20);
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd7;
      #1;
      vectors++; if (Stall_ID !== 1'b1) begin miscompares++;
         $display("[TB] FAIL hz_stall_rs: got %b expected 1", Stall_ID); end
      tick();
      idleInputs();
      Uses_Rt_ID = 1'b1; Read_Register_2_ID = 5'd7;
      #1;
      vectors++; if (Stall_ID !== 1'b1) begin miscompares++;
         $display("[TB] FAIL hz_stall_rt: got %b expected 1", Stall_ID); end
      Uses_Rt_ID = 1'b0; Read_Register_1_ID = 5'd7;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL hz_unused_src: got %b expected 0", Stall_ID); end
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd20;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL hz_blocked_issue: got %b expected 0", Stall_ID); end
      tick();
      retireAlu(5'd7, 32'h0000_7777);
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd7;
      #1;
      vectors++; if (Stall_ID !== !BypassEn) begin miscompares++;
         $display("[TB] FAIL hz_retire_stall: got %b expected %b", Stall_ID, !BypassEn); end
      vectors++; if (Read_Data_1_ID !== (BypassEn ? 32'h7777 : 32'h0)) begin miscompares++;
         $display("[TB] FAIL hz_retire_read: got %h expected %h", Read_Data_1_ID,
                  (BypassEn ? 32'h7777 : 32'h0)); end
      tick();
      RegWrite_WB = 1'b0;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL hz_after_stall: got %b expected 0", Stall_ID); end
      vectors++; if (Read_Data_1_ID !== 32'h7777) begin miscompares++;
         $display("[TB] FAIL hz_after_read: got %h expected %h", Read_Data_1_ID, 32'h7777); end
   endtask

   task automatic test_simultaneous();
      issueWrite(5'd9);
      tick();
      issueWrite(5'd9);
      RegWrite_WB = 1'b1; Write_Register_WB = 5'd9; ALU_Result_WB = 32'h9;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL sim_no_stall: got %b expected 0", Stall_ID); end
      tick();
      idleInputs();
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd9;
      #1;
      vectors++; if (Stall_ID !== 1'b1) begin miscompares++;
         $display("[TB] FAIL sim_count_held: got %b expected 1", Stall_ID); end
      vectors++; if (Read_Data_1_ID !== 32'h9) begin miscompares++;
         $display("[TB] FAIL sim_first_write: got %h expected %h", Read_Data_1_ID, 32'h9); end
      tick();
      retireAlu(5'd9, 32'h99);
      tick();
      idleInputs();
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd9;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL sim_drained: got %b expected 0", Stall_ID); end
      vectors++; if (Read_Data_1_ID !== 32'h99) begin miscompares++;
         $display("[TB] FAIL sim_read: got %h expected %h", Read_Data_1_ID, 32'h99); end
      vectors++; if (Sb_Error !== 1'b0) begin miscompares++;
         $display("[TB] FAIL sim_sberr: got %b expected 0", Sb_Error); end
   endtask

   task automatic test_zero_reg();
      issueWrite(5'd0);
      RegWrite_WB = 1'b1; Write_Register_WB = 5'd0; ALU_Result_WB = 32'hFFFF_FFFF;
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd0;
      Uses_Rt_ID = 1'b1; Read_Register_2_ID = 5'd0;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL zr_stall_wb: got %b expected 0", Stall_ID); end
      vectors++; if (Read_Data_1_ID !== 32'd0) begin miscompares++;
         $display("[TB] FAIL zr_read_wb: got %h expected %h", Read_Data_1_ID, 32'd0); end
      tick();
      idleInputs();
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd0;
      Uses_Rt_ID = 1'b1; Read_Register_2_ID = 5'd0;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL zr_stall_after: got %b expected 0", Stall_ID); end
      vectors++; if (Read_Data_2_ID !== 32'd0) begin miscompares++;
         $display("[TB] FAIL zr_read_after: got %h expected %h", Read_Data_2_ID, 32'd0); end
      vectors++; if (Sb_Error !== 1'b0) begin miscompares++;
         $display("[TB] FAIL zr_sberr: got %b expected 0", Sb_Error); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) begin
         issueWrite(5'd3);
         #1;
         if (i == 3) begin
            vectors++; if (Sb_Error !== 1'b0) begin miscompares++;
               $display("[TB] FAIL ov_sberr_at_max: got %b expected 0", Sb_Error); end
         end
         tick();
      end
      idleInputs();
      #1;
      vectors++; if (Sb_Error !== 1'b1) begin miscompares++;
         $display("[TB] FAIL ov_sberr_set: got %b expected 1", Sb_Error); end
      retireAlu(5'd3, 32'h31);
      tick();
      retireAlu(5'd3, 32'h32);
      tick();
      idleInputs();
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd3;
      #1;
      vectors++; if (Stall_ID !== 1'b1) begin miscompares++;
         $display("[TB] FAIL ov_one_left: got %b expected 1", Stall_ID); end
      tick();
      retireAlu(5'd3, 32'h33);
      tick();
      idleInputs();
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd3;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL ov_saturated_drain: got %b expected 0", Stall_ID); end
      vectors++; if (Sb_Error !== 1'b1) begin miscompares++;
         $display("[TB] FAIL ov_sberr_sticky: got %b expected 1", Sb_Error); end
   endtask

   task automatic test_reset_midflight();
      issueWrite(5'd15);
      tick();
      idleInputs();
      Uses_Rs_ID = 1'b1; Read_Register_1_ID = 5'd15;
      Read_Register_2_ID = 5'd5;
      #1;
      vectors++; if (Stall_ID !== 1'b1) begin miscompares++;
         $display("[TB] FAIL mr_pending: got %b expected 1", Stall_ID); end
      Reset_n = 1'b0;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL mr_reset_stall: got %b expected 0", Stall_ID); end
      vectors++; if (Read_Data_2_ID !== 32'd0) begin miscompares++;
         $display("[TB] FAIL mr_reset_read: got %h expected %h", Read_Data_2_ID, 32'd0); end
      vectors++; if (Sb_Error !== 1'b0) begin miscompares++;
         $display("[TB] FAIL mr_reset_sberr: got %b expected 0", Sb_Error); end
      tick();
      Reset_n = 1'b1;
      #1;
      vectors++; if (Stall_ID !== 1'b0) begin miscompares++;
         $display("[TB] FAIL mr_first_cycle: got %b expected 0", Stall_ID); end
      // A late write-back for the discarded $15 entry has no count to retire.
      retireAlu(5'd15, 32'h15);
      #1;
      vectors++; if (Sb_Error !== 1'b0) begin miscompares++;
         $display("[TB] FAIL mr_sberr_before: got %b expected 0", Sb_Error); end
      tick();
      idleInputs();
      Read_Register_1_ID = 5'd15;
      #1;
      vectors++; if (Sb_Error !== 1'b1) begin miscompares++;
         $display("[TB] FAIL mr_orphan_sberr: got %b expected 1", Sb_Error); end
      vectors++; if (Read_Data_1_ID !== 32'h15) begin miscompares++;
         $display("[TB] FAIL mr_orphan_write: got %h expected %h", Read_Data_1_ID, 32'h15); end
   endtask

   initial begin
      test_reset();
      test_issue_retire();
      test_load_writeback();
      test_hazard();
      test_simultaneous();
      test_zero_reg();
      test_overflow();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
